pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Pipeline sequencing controller for the RV32I core. It sits beside instruction_decode and drives the IF/ID and ID/EX register enables and flushes. It detects load-use and RAW hazards against an internal scoreboard, resolves EX-stage redirects (taken branch, jump) and freezes the pipe while data memory is busy. It also keeps stall and flush performance counters.

Parameters:
DATA_WIDTH, 32, instruction width
REG_ADDR, 5, register index width
FORWARDING, 1, 1 = EX/MA forwarding exists, stall only on load-use; 0 = stall on any RAW with an in-flight writer
CNT_WIDTH, 16, performance counter width

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
i_if_inst  input  DATA_WIDTH  instruction held in IF/ID (being decoded)
i_id_reg_wr  input  1  EX-stage instruction writes rd (o_id_reg_wr)
i_id_mem_rd  input  1  EX-stage instruction is a load (o_id_mem_rd)
i_id_reg_destination  input  REG_ADDR  EX-stage rd
i_ex_redirect  input  1  EX resolved taken branch/jump this cycle
i_mem_busy  input  1  data memory not ready; whole pipe must hold
o_pc_en  output  1  PC update enable
o_if_clk_en  output  1  IF/ID register enable
o_id_clk_en  output  1  ID/EX register enable (instruction_decode clk_en)
o_if_flush  output  1  clear IF/ID to NOP
o_id_flush  output  1  insert bubble into ID/EX (instruction_decode i_flush)
o_stall_count  output  CNT_WIDTH  cycles with o_pc_en=0 outside reset
o_flush_count  output  CNT_WIDTH  redirects taken

Behaviour:
- Reset (rst=1, async): state RUN, scoreboard cleared, counters 0. Outputs: o_pc_en=0, o_if_clk_en=0, o_id_clk_en=0, o_if_flush=1, o_id_flush=1.
- Source decode from i_if_inst[6:0]:
  - rs1 used for JALR, LOAD, OP-IMM, OP, STORE, BRANCH.
  - rs2 used for OP, STORE, BRANCH.
  - LUI, AUIPC, JAL use neither.
  - A source index of x0 never creates a hazard.
- Scoreboard: two entries, EX and MA, each {valid, rd, is_load}.
  - EX entry is taken from the i_id_* inputs.
  - MA entry is a register loaded from EX whenever o_id_clk_en=1.
  - A bubble (o_id_flush) shifts in valid=0.
  - Entries with rd=0 are invalid.
- Priority, highest first: rst > i_mem_busy > i_ex_redirect > load-use > RAW (FORWARDING=0 only).
- FSM states: RUN, LOAD_STALL, RAW_STALL, MEM_WAIT.
- RUN, no event: all enables 1, flushes 0.
- Load-use: the EX entry is a valid load whose rd matches a used source.
  - Same cycle: o_pc_en=0, o_if_clk_en=0, o_id_clk_en=1, o_id_flush=1.
  - Go to LOAD_STALL; exactly one bubble is inserted, then return to RUN.
  - The hazard is not re-detected against the bubble.
- RAW (FORWARDING=0): any valid EX or MA entry rd matches a used source.
  - Stall as for load-use and go to RAW_STALL.
  - Remain there, inserting a bubble each cycle, until no entry matches, then RUN. Worst case is 2 cycles.
- Redirect: i_ex_redirect=1 in RUN, LOAD_STALL or RAW_STALL.
  - Same cycle: o_if_flush=1, o_id_flush=1, o_pc_en=1, o_if_clk_en=1, o_id_clk_en=1.
  - Any pending stall is abandoned and the state goes to RUN.
  - o_flush_count increments.
- i_mem_busy=1 in any state:
  - All enables 0, flushes 0, scoreboard frozen; go to MEM_WAIT.
  - An i_ex_redirect seen during busy is ignored (EX holds it).
  - When busy drops, re-evaluate from RUN on the same cycle.
- o_stall_count increments each cycle o_pc_en=0 (rst=0). Both counters saturate at all-ones.
- Outputs are combinational from state, scoreboard and inputs; the state and scoreboard are the only sequential state besides the counters.

Decomposition:
- Shared core package: opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP), DATA_WIDTH and REG_ADDR, and hazard_state_t (enum of the four states).
- One natural sub-module, src_usage_decode: combinational; i_if_inst → rs1, rs2, rs1_used, rs2_used.

Test Plan:
- LW x5,0(x6) in EX (i_id_mem_rd=1, rd=5), IF/ID = ADD x7,x5,x1 (0x001283b3) → one cycle of o_pc_en=0, o_id_flush=1, then RUN; o_stall_count=1.
- Load rd=0 in EX, IF/ID = ADD x7,x0,x1 → no stall; all enables 1.
- ADD x4,... rd=4 in EX with FORWARDING=0, consumer uses x4 → exactly 2 bubble cycles; FORWARDING=1 → 0 bubbles.
- Load-use stall cycle with i_ex_redirect=1 → o_if_flush=1, o_id_flush=1, o_pc_en=1, state RUN, o_flush_count=1.
- i_mem_busy high 3 cycles during LOAD_STALL → all enables 0 for 3 cycles, no flush; afterwards the single bubble completes.
- rst asserted mid RAW_STALL (async, between edges) → outputs go immediately to reset values; after release: RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller:
// RV32I opcodes, core widths and the sequencer state type.
package pipeline_hazard_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR   = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_RAW_STALL,
    ST_MEM_WAIT
  } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_src_usage_decode.sv
// Source-register usage decode of the IF/ID instruction.
// in: i_inst; out: o_rs1/o_rs2 indices, o_rs1_used/o_rs2_used.
module src_usage_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic [DATA_WIDTH-1:0] i_inst,
  output logic [REG_ADDR-1:0]   o_rs1,
  output logic [REG_ADDR-1:0]   o_rs2,
  output logic                  o_rs1_used,
  output logic                  o_rs2_used
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [6:0] opcode;
  logic       unused_inst;

  assign opcode = i_inst[6:0];
  assign o_rs1  = i_inst[15 +: REG_ADDR];
  assign o_rs2  = i_inst[20 +: REG_ADDR];

  // Remaining instruction bits carry no source info.
  assign unused_inst = ^i_inst;

  always_comb begin
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    unique case (opcode)
      OP_OP, OP_STORE, OP_BRANCH: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        o_rs1_used = 1'b1;
      end
      default: begin
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use/RAW stalls, EX redirects,
// memory-busy freeze, stall/flush performance counters.
// in : clk, rst, i_if_inst, i_id_reg_wr, i_id_mem_rd,
//      i_id_reg_destination, i_ex_redirect, i_mem_busy
// out: o_pc_en, o_if_clk_en, o_id_clk_en, o_if_flush,
//      o_id_flush, o_stall_count, o_flush_count
module pipeline_hazard_ctrl #(
  parameter int DATA_WIDTH = pipeline_hazard_ctrl_pkg::DATA_WIDTH,
  parameter int REG_ADDR   = pipeline_hazard_ctrl_pkg::REG_ADDR,
  parameter int FORWARDING = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_if_inst,
  input  logic                  i_id_reg_wr,
  input  logic                  i_id_mem_rd,
  input  logic [REG_ADDR-1:0]   i_id_reg_destination,
  input  logic                  i_ex_redirect,
  input  logic                  i_mem_busy,
  output logic                  o_pc_en,
  output logic                  o_if_clk_en,
  output logic                  o_id_clk_en,
  output logic                  o_if_flush,
  output logic                  o_id_flush,
  output logic [CNT_WIDTH-1:0]  o_stall_count,
  output logic [CNT_WIDTH-1:0]  o_flush_count
);
  import pipeline_hazard_ctrl_pkg::*;

  typedef struct packed {
    logic                valid;
    logic [REG_ADDR-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  hazard_state_t state_q, state_d;
  sb_entry_t     ma_q, ma_d;
  sb_entry_t     ex_ent;
  logic          ex_bubble_q, ex_bubble_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic [REG_ADDR-1:0] rs1, rs2;
  logic rs1_used, rs2_used;
  logic ex_hit, ma_hit;
  logic load_use, raw_hit;
  logic redirect_take;
  logic unused_sb;

  src_usage_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR   (REG_ADDR)
  ) u_src_dec (
    .i_inst     (i_if_inst),
    .o_rs1      (rs1),
    .o_rs2      (rs2),
    .o_rs1_used (rs1_used),
    .o_rs2_used (rs2_used)
  );

  // EX entry mirrors the decode outputs, except when the
  // slot holds a bubble we inserted (decode view is stale).
  always_comb begin
    ex_ent.valid   = i_id_reg_wr
                   & (i_id_reg_destination != '0)
                   & ~ex_bubble_q;
    ex_ent.rd      = i_id_reg_destination;
    ex_ent.is_load = i_id_mem_rd;
  end

  function automatic logic src_hit(
    input logic                valid,
    input logic [REG_ADDR-1:0] rd
  );
    logic h1, h2;
    h1 = rs1_used & (rs1 != '0) & (rs1 == rd);
    h2 = rs2_used & (rs2 != '0) & (rs2 == rd);
    return valid & (h1 | h2);
  endfunction

  assign ex_hit = src_hit(ex_ent.valid, ex_ent.rd);
  assign ma_hit = src_hit(ma_q.valid, ma_q.rd);

  // A consumer released from LOAD_STALL must not stall on
  // the same load again.
  assign load_use = ex_hit & ex_ent.is_load
                  & (state_q != ST_LOAD_STALL);
  assign raw_hit  = (FORWARDING == 0) & (ex_hit | ma_hit);

  assign redirect_take = ~i_mem_busy & i_ex_redirect;

  assign unused_sb = ma_q.is_load;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (i_mem_busy) begin
      state_d = ST_MEM_WAIT;
    end else if (i_ex_redirect) begin
      state_d = ST_RUN;
    end else if (load_use) begin
      state_d = ST_LOAD_STALL;
    end else if (raw_hit) begin
      state_d = ST_RAW_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output logic
  always_comb begin
    o_pc_en     = 1'b1;
    o_if_clk_en = 1'b1;
    o_id_clk_en = 1'b1;
    o_if_flush  = 1'b0;
    o_id_flush  = 1'b0;
    if (rst) begin
      o_pc_en     = 1'b0;
      o_if_clk_en = 1'b0;
      o_id_clk_en = 1'b0;
      o_if_flush  = 1'b1;
      o_id_flush  = 1'b1;
    end else if (i_mem_busy) begin
      o_pc_en     = 1'b0;
      o_if_clk_en = 1'b0;
      o_id_clk_en = 1'b0;
    end else if (i_ex_redirect) begin
      o_if_flush  = 1'b1;
      o_id_flush  = 1'b1;
    end else if (load_use | raw_hit) begin
      o_pc_en     = 1'b0;
      o_if_clk_en = 1'b0;
      o_id_flush  = 1'b1;
    end
  end

  // Scoreboard: EX moves to MA on every ID/EX advance;
  // a flush leaves a bubble behind in EX.
  always_comb begin
    ma_d        = ma_q;
    ex_bubble_d = ex_bubble_q;
    if (o_id_clk_en) begin
      ma_d        = ex_ent;
      ex_bubble_d = o_id_flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q        <= '0;
      ex_bubble_q <= 1'b0;
    end else begin
      ma_q        <= ma_d;
      ex_bubble_q <= ex_bubble_d;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (~o_pc_en && ~&stall_cnt_q) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_take && ~&flush_cnt_q) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
  assign o_flush_count = flush_cnt_q;

endmodule
